// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: spcon bit positions and slave state encoding.
// The master-side register map imports this package as well.
package spi_slave_pkg;
   localparam int SPCON_EN   = 0;
   localparam int SPCON_CPHA = 1;
   localparam int SPCON_CPOL = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;
endpackage

// File: rtl/spi_sync.sv
// Flop-chain synchronizer for one asynchronous input with a selectable reset value.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= {STAGES{RST_VAL}};
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampling sck/ssn/mosi in the clk domain.
// Full-duplex MSB-first byte shifting with continuous-byte support while ssn stays low.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] spcon,
   input  logic [7:0] data_s,
   output logic [7:0] data_r_s,
   output logic       rx_valid,
   output logic       busy,
   input  logic       sck,
   input  logic       ssn,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe
);
   logic sck_s, ssn_s, mosi_s, sck_d;
   spi_state_e state_q, state_d;
   logic       cpol_q, cpha_q, reload_q, armed_q;
   logic [2:0] cnt_q;
   logic [6:0] rx_sr;
   logic [7:0] tx_sr;
   logic [SYNC_STAGES-1:0] settle_q;
   logic enable, lead, trail, sample, shift, enter, stay;
   logic unused_spcon;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck
      (.clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn
      (.clk(clk), .rst_n(rst_n), .d(ssn), .q(ssn_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi
      (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

   assign enable       = spcon[SPCON_EN];
   assign unused_spcon = ^spcon[7:3];

   // Leading edge leaves the idle level cpol, trailing edge returns to it.
   assign lead   = (sck_s != sck_d) && (sck_d == cpol_q);
   assign trail  = (sck_s != sck_d) && (sck_d != cpol_q);
   assign sample = cpha_q ? trail : lead;
   assign shift  = cpha_q ? lead  : trail;
   assign enter  = (state_q == ST_IDLE)   && (state_d == ST_ACTIVE);
   assign stay   = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);

   assign busy    = (state_q == ST_ACTIVE);
   assign miso_oe = busy;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (enable && !ssn_s && armed_q) state_d = ST_ACTIVE;
         ST_ACTIVE: if (ssn_s || !enable)            state_d = ST_IDLE;
      endcase
   end

   // After reset the synchronizers must flush and ssn must be seen high,
   // so a select still held low from before the reset is not taken as a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sck_d    <= 1'b0;
         settle_q <= '0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sck_d    <= sck_s;
         settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
         armed_q  <= armed_q | (settle_q[SYNC_STAGES-1] & ssn_s);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         cnt_q    <= 3'd0;
         reload_q <= 1'b0;
         rx_sr    <= 7'd0;
         tx_sr    <= 8'd0;
         data_r_s <= 8'd0;
         rx_valid <= 1'b0;
         miso     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (enter) begin
            cpol_q   <= spcon[SPCON_CPOL];
            cpha_q   <= spcon[SPCON_CPHA];
            cnt_q    <= 3'd0;
            reload_q <= 1'b0;
            if (!spcon[SPCON_CPHA]) begin
               miso  <= data_s[7];
               tx_sr <= {data_s[6:0], 1'b0};
            end else begin
               miso  <= 1'b0;
               tx_sr <= data_s;
            end
         end else if (stay) begin
            if (sample) begin
               rx_sr <= {rx_sr[5:0], mosi_s};
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  data_r_s <= {rx_sr, mosi_s};
                  rx_valid <= 1'b1;
                  reload_q <= 1'b1;
               end
            end
            // The first shift after a completed byte starts the next byte from data_s.
            if (shift) begin
               if (reload_q) begin
                  miso     <= data_s[7];
                  tx_sr    <= {data_s[6:0], 1'b0};
                  reload_q <= 1'b0;
               end else begin
                  miso  <= tx_sr[7];
                  tx_sr <= {tx_sr[6:0], 1'b0};
               end
            end
         end else if (state_q == ST_ACTIVE) begin
            miso     <= 1'b0;
            cnt_q    <= 3'd0;
            reload_q <= 1'b0;
         end
      end
   end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sck, ssn and mosi (legal values 2..3).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port spcon, input, 8 bits: bit0 = enable, bit1 = cpha, bit2 = cpol, bits7:3 ignored.
REQ-005 SHALL have port data_s, input, 8 bits: transmit byte, sampled at each byte load.
REQ-006 SHALL have port data_r_s, output reg, 8 bits: last complete received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-clk pulse when data_r_s updates.
REQ-008 SHALL have port busy, output, 1 bit: high while in ACTIVE.
REQ-009 SHALL have port sck, input, 1 bit: SPI clock from the master, asynchronous to clk.
REQ-010 SHALL have port ssn, input, 1 bit: slave select, active low.
REQ-011 SHALL have port mosi, input, 1 bit: serial data in.
REQ-012 SHALL have port miso, output reg, 1 bit: serial data out.
REQ-013 SHALL have port miso_oe, output, 1 bit: tristate enable, high only in ACTIVE.

Function
REQ-014 SHALL pass sck, ssn and mosi through SYNC_STAGES flops; all decisions use the synchronized values.
REQ-015 SHALL detect sck edges by comparing the synchronized sck with its one-cycle-delayed copy; the leading edge is the transition away from cpol, the trailing edge the transition back to cpol.
REQ-016 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE when enable=1 and synchronized ssn=0; ACTIVE->IDLE when synchronized ssn=1 or enable=0.
REQ-017 SHALL, on entry to ACTIVE, load the tx shifter from data_s, clear the bit counter to 0, and drive miso = data_s[7] when cpha=0.
REQ-018 SHALL, for cpha=0, sample mosi on the leading edge and shift the next bit out on the trailing edge.
REQ-019 SHALL, for cpha=1, shift a bit out on the leading edge (first leading edge drives bit 7) and sample mosi on the trailing edge.
REQ-020 SHALL shift both directions MSB first; the rx shift register takes {rx[6:0], mosi}.
REQ-021 SHALL use a 3-bit sample counter; on the 8th sample, load data_r_s from {rx[6:0], mosi} and assert rx_valid for exactly one clk in the following cycle.
REQ-022 SHALL, when ssn stays low after 8 samples, wrap the counter to 0 and reload the tx shifter from data_s; for cpha=0 the reload drives bit 7 on the trailing edge that follows the 8th sample.
REQ-023 SHALL, when ssn deasserts mid-byte, discard the partial byte, leave data_r_s unchanged and not pulse rx_valid.
REQ-024 SHALL ignore sck edges in IDLE; cpol and cpha changes take effect only at the next IDLE->ACTIVE entry, because they are latched on entry.
REQ-025 SHALL support sck high and low phases each of at least SYNC_STAGES+2 clk periods; no behaviour is guaranteed for faster sck.
REQ-026 SHALL hold miso at 0 and miso_oe at 0 in IDLE.

Reset
REQ-027 SHALL, while rst_n=0, reset to: state IDLE, data_r_s=0, rx_valid=0, miso=0, miso_oe=0, busy=0, counter=0, synchronizer flops for sck at 0, ssn at 1, mosi at 0.
REQ-028 SHALL abort any transfer in progress when reset is asserted; after release it waits for a fresh ssn falling edge.

Structure
REQ-029 SHALL place the spcon bit indices (EN=0, CPHA=1, CPOL=2) and the state encoding in a shared package also used by the master-side register map.
REQ-030 SHALL implement the flop chain in one sub-module, spi_sync, instantiated once per asynchronous input.

Verification
REQ-031 SHALL cover mode 0 (cpol=0, cpha=0), sck = clk/16, master sends 0xA5 while data_s=0x3C -> data_r_s=0xA5, exactly one rx_valid pulse, master receives 0x3C.
REQ-032 SHALL cover mode 3 (cpol=1, cpha=1), master sends 0x81 while data_s=0x7E -> data_r_s=0x81 and master receives 0x7E.
REQ-033 SHALL cover two back-to-back bytes 0x12, 0x34 with ssn held low, data_s changed 0x55->0xAA after the first rx_valid -> two pulses, data_r_s 0x12 then 0x34, miso bytes 0x55 then 0xAA.
REQ-034 SHALL cover ssn deasserted after 5 bits, then a full byte 0xF0 -> no pulse for the aborted byte, data_r_s=0xF0 after the second transfer.
REQ-035 SHALL cover enable=0 with 8 sck edges -> busy=0, miso_oe=0, no rx_valid.
REQ-036 SHALL cover rst_n asserted mid-byte in mode 1 -> all outputs at their reset values immediately, and the next full byte 0xC3 is received correctly.
